// File: rtl/jtag_dmi_dtm.sv
// rtl/jtag_dmi_dtm.sv - soft JTAG TAP with RISC-V DTM registers (IDCODE/DTMCS/DMI/BYPASS)
// TCK/TMS/TDI are oversampled into clk; the whole TAP and DMI front end run on clk.
module jtag_dmi_dtm #(
  parameter int          AWIDTH      = 7,
  parameter int          IRLEN       = 5,
  parameter logic [31:0] IDCODE      = 32'hDEADBEEF,
  parameter int          SYNC_STAGES = 2,
  parameter int          IDLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tck,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_oe,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [AWIDTH-1:0] dmi_req_addr,
  output logic [31:0]       dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_resp_valid,
  input  logic [31:0]       dmi_resp_data,
  input  logic [1:0]        dmi_resp_op,
  output logic              dmi_hard_reset
);

  localparam int DW = AWIDTH + 34;
  localparam logic [IRLEN-1:0] IR_IDCODE = IRLEN'(5'h01);
  localparam logic [IRLEN-1:0] IR_DTMCS  = IRLEN'(5'h10);
  localparam logic [IRLEN-1:0] IR_DMI    = IRLEN'(5'h11);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic tck_q, tck_s, tms_s, tdi_s, rise, fall;

  tap_state_t state, state_n;

  logic [DW-1:0]     dr, dr_cap, dr_sh;
  logic [IRLEN-1:0]  ir_sr, ir;
  logic [1:0]        sticky, sticky_r, sticky_n, status_r;
  logic              busy, busy_r, busy_n, resp_take;
  logic [31:0]       rdata, rdata_r, rdata_n, dtmcs_val;
  logic [AWIDTH-1:0] last_addr, last_addr_n, req_addr_n;
  logic [31:0]       req_data_n;
  logic [1:0]        req_op_n;
  logic              req_valid_n, hard_reset_n;
  logic              cap_dmi, upd_dmi, upd_dtmcs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_q    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_q    <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_s = tck_sync[SYNC_STAGES-1];
  assign tms_s = tms_sync[SYNC_STAGES-1];
  assign tdi_s = tdi_sync[SYNC_STAGES-1];
  assign rise  = tck_s & ~tck_q;
  assign fall  = ~tck_s & tck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TLR;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (rise) begin
      case (state)
        TLR:      state_n = tms_s ? TLR      : RTI;
        RTI:      state_n = tms_s ? SEL_DR   : RTI;
        SEL_DR:   state_n = tms_s ? SEL_IR   : CAP_DR;
        CAP_DR:   state_n = tms_s ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_n = tms_s ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_n = tms_s ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_n = tms_s ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_n = tms_s ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_n = tms_s ? SEL_DR   : RTI;
        SEL_IR:   state_n = tms_s ? TLR      : CAP_IR;
        CAP_IR:   state_n = tms_s ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_n = tms_s ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_n = tms_s ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_n = tms_s ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_n = tms_s ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_n = tms_s ? SEL_DR   : RTI;
      endcase
    end
  end

  // Response is folded in before any capture/update in the same clk sees the status.
  assign resp_take = dmi_resp_valid & busy;

  always_comb begin
    busy_r   = resp_take ? 1'b0 : busy;
    rdata_r  = resp_take ? dmi_resp_data : rdata;
    sticky_r = (resp_take && dmi_resp_op != 2'd0 && sticky == 2'd0) ? 2'd2 : sticky;
    status_r = (sticky_r != 2'd0) ? sticky_r : (busy_r ? 2'd3 : 2'd0);
  end

  assign dtmcs_val = {17'b0, 3'(IDLE_CYCLES), status_r, 6'(AWIDTH), 4'd1};

  always_comb begin
    dr_cap = '0;
    if (ir == IR_IDCODE)     dr_cap = DW'(IDCODE);
    else if (ir == IR_DTMCS) dr_cap = DW'(dtmcs_val);
    else if (ir == IR_DMI)   dr_cap = {last_addr, rdata_r, status_r};
  end

  // TDI enters the MSB of whichever register is selected; BYPASS is one bit.
  always_comb begin
    dr_sh = dr >> 1;
    if (ir == IR_IDCODE || ir == IR_DTMCS) begin
      dr_sh[31] = tdi_s;
    end else if (ir == IR_DMI) begin
      dr_sh[DW-1] = tdi_s;
    end else begin
      dr_sh    = '0;
      dr_sh[0] = tdi_s;
    end
  end

  assign cap_dmi   = rise && state == CAP_DR && ir == IR_DMI;
  assign upd_dtmcs = fall && state == UPD_DR && ir == IR_DTMCS;
  assign upd_dmi   = fall && state == UPD_DR && ir == IR_DMI &&
                     (dr[1:0] == 2'd1 || dr[1:0] == 2'd2);

  always_comb begin
    sticky_n     = sticky_r;
    busy_n       = busy_r;
    rdata_n      = rdata_r;
    last_addr_n  = last_addr;
    req_valid_n  = dmi_req_valid & ~dmi_req_ready;
    req_addr_n   = dmi_req_addr;
    req_data_n   = dmi_req_data;
    req_op_n     = dmi_req_op;
    hard_reset_n = 1'b0;
    if (cap_dmi && busy_r && sticky_r == 2'd0) sticky_n = 2'd3;
    if (upd_dtmcs && dr[17]) begin
      sticky_n     = 2'd0;
      busy_n       = 1'b0;
      hard_reset_n = 1'b1;
    end else if (upd_dtmcs && dr[16]) begin
      sticky_n = 2'd0;
    end
    // A request still waiting on its handshake blocks a new one just like busy.
    if (upd_dmi) begin
      if (busy_r || dmi_req_valid) begin
        sticky_n = 2'd3;
      end else if (sticky_r == 2'd0) begin
        req_valid_n = 1'b1;
        req_addr_n  = dr[DW-1:34];
        req_data_n  = dr[33:2];
        req_op_n    = dr[1:0];
        last_addr_n = dr[DW-1:34];
        busy_n      = 1'b1;
      end
    end
    if (state == TLR) sticky_n = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky         <= 2'd0;
      busy           <= 1'b0;
      rdata          <= '0;
      last_addr      <= '0;
      dmi_req_valid  <= 1'b0;
      dmi_req_addr   <= '0;
      dmi_req_data   <= '0;
      dmi_req_op     <= 2'd0;
      dmi_hard_reset <= 1'b0;
    end else begin
      sticky         <= sticky_n;
      busy           <= busy_n;
      rdata          <= rdata_n;
      last_addr      <= last_addr_n;
      dmi_req_valid  <= req_valid_n;
      dmi_req_addr   <= req_addr_n;
      dmi_req_data   <= req_data_n;
      dmi_req_op     <= req_op_n;
      dmi_hard_reset <= hard_reset_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr     <= '0;
      ir_sr  <= '0;
      ir     <= IR_IDCODE;
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else begin
      if (rise) begin
        if (state == CAP_DR)        dr <= dr_cap;
        else if (state == SHIFT_DR) dr <= dr_sh;
        if (state == CAP_IR)        ir_sr <= IRLEN'(2'b01);
        else if (state == SHIFT_IR) ir_sr <= {tdi_s, ir_sr[IRLEN-1:1]};
      end
      if (fall) begin
        tdo_oe <= (state == SHIFT_IR) || (state == SHIFT_DR);
        tdo    <= (state == SHIFT_IR) ? ir_sr[0] : (state == SHIFT_DR) ? dr[0] : 1'b0;
      end
      if (state == TLR)                    ir <= IR_IDCODE;
      else if (fall && state == UPD_IR)    ir <= ir_sr;
    end
  end

endmodule

// File: tb/tb_jtag_dmi_dtm.sv
// tb/tb_jtag_dmi_dtm.sv - scoreboard bench for jtag_dmi_dtm driving TCK well below clk/8
module tb_jtag_dmi_dtm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic        tdo, tdo_oe;
  logic        dmi_req_valid, dmi_req_ready = 1'b0;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_resp_valid = 1'b0;
  logic [31:0] dmi_resp_data = '0;
  logic [1:0]  dmi_resp_op = '0;
  logic        dmi_hard_reset;

  int errors = 0;
  int checks = 0;
  int hr_count = 0;
  logic [63:0] exp_q[$];
  logic [40:0] exp_req_q[$];
  logic [40:0] obs_q[$];
  logic [44:0] all_out;

  assign all_out = {tdo, tdo_oe, dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_hard_reset};

  jtag_dmi_dtm dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
    .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_resp_valid(dmi_resp_valid),
    .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op), .dmi_hard_reset(dmi_hard_reset)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && dmi_req_valid && dmi_req_ready)
      obs_q.push_back({dmi_req_addr, dmi_req_data, dmi_req_op});

  always @(negedge clk)
    if (dmi_hard_reset) hr_count++;

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  task automatic jtag_cycle(input bit tms_v, input bit tdi_v, output bit tdo_v, output bit oe_v);
    tms = tms_v; tdi = tdi_v;
    #40; tck = 1'b1;
    #80; tck = 1'b0;
    #60; tdo_v = tdo; oe_v = tdo_oe;
    #20;
  endtask

  // Starts and ends in Run-Test/Idle; dout collects TDO LSB first.
  task automatic scan(input bit is_ir, input logic [63:0] din, input int len,
                      output logic [63:0] dout, output bit oe_ok);
    bit t, o;
    dout = '0; oe_ok = 1'b1;
    jtag_cycle(1'b1, 1'b0, t, o);
    if (is_ir) jtag_cycle(1'b1, 1'b0, t, o);
    jtag_cycle(1'b0, 1'b0, t, o);
    if (o) oe_ok = 1'b0;
    jtag_cycle(1'b0, 1'b0, t, o);
    for (int i = 0; i < len; i++) begin
      dout[i] = t;
      if (!o) oe_ok = 1'b0;
      jtag_cycle(i == len - 1, din[i], t, o);
    end
    if (o) oe_ok = 1'b0;
    jtag_cycle(1'b1, 1'b0, t, o);
    jtag_cycle(1'b0, 1'b0, t, o);
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] op);
    @(negedge clk);
    dmi_resp_valid = 1'b1; dmi_resp_data = d; dmi_resp_op = op;
    @(negedge clk);
    dmi_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit t, o, ok; logic [63:0] d, e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    rst_n = 1'b1;
    @(negedge clk);
    repeat (5) jtag_cycle(1'b1, 1'b0, t, o);
    jtag_cycle(1'b0, 1'b0, t, o);
    exp_q.push_back(64'hDEADBEEF);
    scan(1'b0, 64'h0, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL idcode_after_reset: got %h want %h", d, e); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tdo_oe_window: got %b want 1", ok); end
  endtask

  task automatic test_dtmcs();
    bit ok; logic [63:0] d, e;
    exp_q.push_back(64'h1);
    scan(1'b1, 64'h10, 5, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL ir_capture: got %h want %h", d, e); end
    exp_q.push_back(64'h00003071);
    scan(1'b0, 64'h0, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL dtmcs_read: got %h want %h", d, e); end
  endtask

  task automatic test_bypass();
    bit ok; logic [63:0] d, e;
    scan(1'b1, 64'h1F, 5, d, ok);
    exp_q.push_back(64'h66);
    scan(1'b0, 64'hB3, 8, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL bypass_shift: got %h want %h", d, e); end
  endtask

  task automatic test_tlr();
    bit t, o, ok; logic [63:0] d, e;
    scan(1'b1, 64'h10, 5, d, ok);
    repeat (5) jtag_cycle(1'b1, 1'b0, t, o);
    jtag_cycle(1'b0, 1'b0, t, o);
    exp_q.push_back(64'hDEADBEEF);
    scan(1'b0, 64'h0, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL tlr_ir_idcode: got %h want %h", d, e); end
  endtask

  task automatic test_dmi_write();
    bit ok; logic [63:0] d, e; logic [40:0] r, er;
    dmi_req_ready = 1'b0;
    scan(1'b1, 64'h11, 5, d, ok);
    exp_q.push_back(dmi_word(7'h00, 32'h0, 2'd0));
    exp_req_q.push_back({7'h10, 32'h1, 2'd2});
    scan(1'b0, dmi_word(7'h10, 32'h1, 2'd2), 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL dmi_first_capture: got %h want %h", d, e); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op} !== {1'b1, 7'h10, 32'h1, 2'd2}) begin
        errors++; $display("FAIL req_hold[%0d]: got v=%b a=%h d=%h op=%0d want 1/10/1/2", i,
                           dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op);
      end
    end
    dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
    checks++; if (dmi_req_valid !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", dmi_req_valid); end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL write_handshakes: got %0d want 1", obs_q.size());
    end else begin
      r = obs_q.pop_front(); er = exp_req_q.pop_front();
      checks++; if (r !== er) begin errors++; $display("FAIL write_req: got %h want %h", r, er); end
    end
    obs_q.delete(); exp_req_q.delete();
    respond(32'h0, 2'd0);
    exp_q.push_back(dmi_word(7'h10, 32'h0, 2'd0));
    scan(1'b0, 64'h0, 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL write_status_ok: got %h want %h", d, e); end
  endtask

  task automatic wait_req(input string name);
    logic [40:0] r, er;
    for (int k = 0; k < 100 && obs_q.size() == 0; k++) @(negedge clk);
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL %s_timeout: got no request want one", name);
      exp_req_q.delete();
    end else begin
      r = obs_q.pop_front(); er = exp_req_q.pop_front();
      if (r !== er) begin errors++; $display("FAIL %s: got %h want %h", name, r, er); end
    end
  endtask

  task automatic test_dmi_busy();
    bit ok; logic [63:0] d, e;
    dmi_req_ready = 1'b1;
    exp_q.push_back(dmi_word(7'h10, 32'h0, 2'd0));
    exp_req_q.push_back({7'h20, 32'h0, 2'd1});
    scan(1'b0, dmi_word(7'h20, 32'h0, 2'd1), 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL read_issue_capture: got %h want %h", d, e); end
    wait_req("read_req");
    exp_q.push_back(dmi_word(7'h20, 32'h0, 2'd3));
    scan(1'b0, dmi_word(7'h21, 32'h0, 2'd1), 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL busy_capture: got %h want %h", d, e); end
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || dmi_req_valid !== 1'b0) begin
      errors++; $display("FAIL no_second_req: got %0d reqs valid=%b want 0", obs_q.size(), dmi_req_valid);
    end
    scan(1'b1, 64'h10, 5, d, ok);
    exp_q.push_back(64'h00003C71);
    scan(1'b0, 64'h0, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL dmistat_busy: got %h want %h", d, e); end
    respond(32'hCAFEF00D, 2'd0);
    exp_q.push_back(64'h00003C71);
    scan(1'b0, 64'h00010000, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL dmistat_sticky: got %h want %h", d, e); end
    exp_q.push_back(64'h00003071);
    scan(1'b0, 64'h0, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL dmireset_clears: got %h want %h", d, e); end
    scan(1'b1, 64'h11, 5, d, ok);
    exp_q.push_back(dmi_word(7'h20, 32'hCAFEF00D, 2'd0));
    scan(1'b0, 64'h0, 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL read_data: got %h want %h", d, e); end
  endtask

  task automatic test_dmi_error();
    bit ok; logic [63:0] d, e; int hr_before;
    exp_q.push_back(dmi_word(7'h20, 32'hCAFEF00D, 2'd0));
    exp_req_q.push_back({7'h05, 32'h0, 2'd1});
    scan(1'b0, dmi_word(7'h05, 32'h0, 2'd1), 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL err_issue_capture: got %h want %h", d, e); end
    wait_req("err_req");
    respond(32'h12345678, 2'd2);
    for (int s = 0; s < 2; s++) begin
      exp_q.push_back(dmi_word(7'h05, 32'h12345678, 2'd2));
      scan(1'b0, 64'h0, 41, d, ok);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL err_sticky[%0d]: got %h want %h", s, d, e); end
    end
    scan(1'b1, 64'h10, 5, d, ok);
    hr_before = hr_count;
    exp_q.push_back(64'h00003871);
    scan(1'b0, 64'h00020000, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL dmistat_err: got %h want %h", d, e); end
    checks++;
    if (hr_count - hr_before != 1) begin
      errors++; $display("FAIL hard_reset_pulse: got %0d clks want 1", hr_count - hr_before);
    end
    exp_q.push_back(64'h00003071);
    scan(1'b0, 64'h0, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL hardreset_dmistat: got %h want %h", d, e); end
    scan(1'b1, 64'h11, 5, d, ok);
    exp_q.push_back(dmi_word(7'h05, 32'h12345678, 2'd0));
    scan(1'b0, 64'h0, 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL hardreset_status: got %h want %h", d, e); end
  endtask

  task automatic test_reset_mid();
    bit t, o, ok, stayed_low; logic [63:0] d, e;
    dmi_req_ready = 1'b0;
    exp_q.push_back(dmi_word(7'h05, 32'h12345678, 2'd0));
    scan(1'b0, dmi_word(7'h33, 32'hA5A5A5A5, 2'd2), 41, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL mid_capture: got %h want %h", d, e); end
    checks++; if (dmi_req_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", dmi_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL async_reset_outputs: got %h want 0", all_out); end
    @(negedge clk);
    rst_n = 1'b1;
    stayed_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmi_req_valid !== 1'b0) stayed_low = 1'b0;
    end
    checks++; if (stayed_low !== 1'b1) begin errors++; $display("FAIL no_req_after_reset: got %b want 1", stayed_low); end
    jtag_cycle(1'b0, 1'b0, t, o);
    exp_q.push_back(64'hDEADBEEF);
    scan(1'b0, 64'h0, 32, d, ok);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL ir_idcode_after_reset: got %h want %h", d, e); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dtmcs();
    test_bypass();
    test_tlr();
    test_dmi_write();
    test_dmi_busy();
    test_dmi_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
